// File: rtl/core_mem_port.sv
// core_mem_port: per-core load/store front end feeding the 16 bank arbiters.
// Queues {we, addr, wdata}, holds the strobe until the bank's finish pulse
// (or a bounded timeout), then returns a one-cycle response.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready = queue not full)
//   req_we/addr/wdata request op, 12-bit address ([11:8] bank), write byte
//   mem_read/write    registered strobes to the bank arbiters
//   mem_addr/wdata    address and write byte, held while idle
//   bank_finish       per-bank finish bit for this core
//   bank_rdata        per-bank read byte for this core (8 bits per bank)
//   resp_valid        one-cycle response pulse
//   resp_we/err       op type echo and timeout flag
//   resp_rdata        read byte (0 for writes and errors), held to next resp
//   busy              queue non-empty or transaction in flight
module core_mem_port #(
    parameter int QDEPTH  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [11:0]  req_addr,
    input  logic [7:0]   req_wdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [11:0]  mem_addr,
    output logic [7:0]   mem_wdata,
    input  logic [15:0]  bank_finish,
    input  logic [127:0] bank_rdata,
    output logic         resp_valid,
    output logic         resp_we,
    output logic [7:0]   resp_rdata,
    output logic         resp_err,
    output logic         busy
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t state;

    logic          q_we    [QDEPTH];
    logic [11:0]   q_addr  [QDEPTH];
    logic [7:0]    q_wdata [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic          cur_we;
    logic [TW-1:0] timer;
    logic [3:0]    bank;
    logic [7:0]    bank_byte;

    assign full      = (count == CW'(QDEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = !empty || (state != IDLE);

    // mem_addr doubles as the in-flight request address register.
    assign bank      = mem_addr[11:8];
    assign bank_byte = bank_rdata[{bank, 3'b000} +: 8];

    // Queue storage carries no reset; validity is tracked by count.
    always_ff @(posedge clock) begin
        if (push) begin
            q_we[wr_ptr]    <= req_we;
            q_addr[wr_ptr]  <= req_addr;
            q_wdata[wr_ptr] <= req_wdata;
        end
    end

    // Power-of-two depth: pointers wrap naturally at PW bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            cur_we     <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_we    <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        cur_we    <= q_we[rd_ptr];
                        mem_addr  <= q_addr[rd_ptr];
                        mem_wdata <= q_wdata[rd_ptr];
                        mem_read  <= !q_we[rd_ptr];
                        mem_write <= q_we[rd_ptr];
                        timer     <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bank_finish[bank]) begin
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_we    <= cur_we;
                        resp_err   <= 1'b0;
                        resp_rdata <= cur_we ? 8'h00 : bank_byte;
                        state      <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_we    <= cur_we;
                        resp_err   <= 1'b1;
                        resp_rdata <= 8'h00;
                        state      <= RESP;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    // resp_rdata deliberately held until the next response.
                    resp_valid <= 1'b0;
                    resp_we    <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_port.sv
// tb_core_mem_port: table-driven bench for core_mem_port with a bank
// responder model and a response scoreboard (TIMEOUT=8, QDEPTH=2).
module tb_core_mem_port;

    localparam int QD = 2;
    localparam int TO = 8;
    localparam logic [127:0] JUNK =
        128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [11:0]  req_addr;
    logic [7:0]   req_wdata;
    logic         mem_read;
    logic         mem_write;
    logic [11:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic [15:0]  bank_finish;
    logic [127:0] bank_rdata;
    logic         resp_valid;
    logic         resp_we;
    logic [7:0]   resp_rdata;
    logic         resp_err;
    logic         busy;

    core_mem_port #(
        .QDEPTH  (QD),
        .TIMEOUT (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .bank_finish (bank_finish),
        .bank_rdata  (bank_rdata),
        .resp_valid  (resp_valid),
        .resp_we     (resp_we),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // delay: strobe cycle on which finish is driven (0 = never -> timeout)
    // stray_at: strobe cycle on which a wrong-bank finish is pulsed (0 = none)
    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        int          delay;
        int          stray_at;
        logic [3:0]  stray_bank;
        logic [7:0]  rdata;
        int          exp_hi;
        logic        exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [8];
    vec_t pending [$];
    vec_t resp_q [$];
    vec_t cur;

    int n_checks = 0;
    int n_fail   = 0;
    bit active   = 1'b0;
    bit mon_en   = 1'b0;
    bit idle_stray = 1'b0;
    int hi       = 0;
    int gap      = 2;
    int stalls   = 0;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event expected none", name);
    endfunction

    // Bank responder + bus checker + response scoreboard, run each negedge.
    function automatic void monitor();
        logic strobe;
        vec_t r;
        strobe      = mem_read | mem_write;
        bank_finish = '0;
        bank_rdata  = JUNK;
        if (!mon_en) begin
            active = 1'b0;
            hi     = 0;
            gap    = 2;
            return;
        end
        if (strobe) begin
            if (!active) begin
                check("strobe_gap", 32'(gap >= 2), 32'd1);
                if (pending.size() == 0) fail_now("unexpected_strobe");
                else cur = pending.pop_front();
                active = 1'b1;
                hi     = 0;
            end
            gap = 0;
            hi++;
            check("mem_bus",
                  {10'd0, mem_read, mem_write, mem_addr, mem_wdata},
                  {10'd0, !cur.we, cur.we, cur.addr, cur.wdata});
            if (hi == cur.delay) begin
                bank_finish[cur.addr[11:8]] = 1'b1;
                bank_rdata[cur.addr[11:8]*8 +: 8] = cur.rdata;
            end
            if (hi == cur.stray_at) bank_finish[cur.stray_bank] = 1'b1;
        end else begin
            if (active) begin
                active = 1'b0;
                check("strobe_cycles", hi, cur.exp_hi);
                resp_q.push_back(cur);
            end
            if (gap < 100) gap++;
            if (idle_stray) begin
                bank_finish = '1;
                idle_stray  = 1'b0;
            end
        end
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                fail_now("unexpected_resp");
            end else begin
                r = resp_q.pop_front();
                check("resp", {22'd0, resp_we, resp_err, resp_rdata},
                      {22'd0, r.we, r.exp_err, r.exp_rdata});
            end
        end
    endfunction

    task automatic tick();
        @(negedge clock);
        monitor();
    endtask

    // Leaves req_valid high after acceptance; caller drops it.
    task automatic push(input vec_t v);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        for (int k = 0; k < 100 && !done; k++) begin
            if (req_ready) begin
                pending.push_back(v);
                done = 1'b1;
            end else begin
                stalls++;
            end
            tick();
        end
        if (!done) fail_now("push_timeout");
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (pending.size() == 0 && resp_q.size() == 0 &&
                !active && !busy)
                done = 1'b1;
            else
                tick();
        end
        if (!done) fail_now("drain_timeout");
    endtask

    initial begin
        int bad;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        bank_finish = '0;
        bank_rdata  = JUNK;

        vecs[0] = '{1'b0, 12'h3A5, 8'h00, 4, 0, 4'd0, 8'h5C, 4, 1'b0, 8'h5C};
        vecs[1] = '{1'b1, 12'hF01, 8'h99, 2, 0, 4'd0, 8'hAA, 2, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 12'h210, 8'h00, 4, 1, 4'd7, 8'h3E, 4, 1'b0, 8'h3E};
        vecs[3] = '{1'b0, 12'h000, 8'h00, 1, 0, 4'd0, 8'h11, 1, 1'b0, 8'h11};
        vecs[4] = '{1'b0, 12'h5FF, 8'h00, 0, 0, 4'd0, 8'h77, 8, 1'b1, 8'h00};
        vecs[5] = '{1'b1, 12'h7AB, 8'h42, 3, 0, 4'd0, 8'h00, 3, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 12'hC80, 8'h00, 7, 0, 4'd0, 8'hE7, 7, 1'b0, 8'hE7};
        vecs[7] = '{1'b0, 12'h9C3, 8'h00, 2, 0, 4'd0, 8'h81, 2, 1'b0, 8'h81};

        tick();
        tick();
        check("reset_ctrl",
              {25'd0, req_ready, busy, mem_read, mem_write,
               resp_valid, resp_we, resp_err},
              32'b100_0000);
        check("reset_data", {4'd0, mem_addr, mem_wdata, resp_rdata}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single requests: read, write, wrong-bank finish, minimum occupancy.
        for (int i = 0; i < 4; i++) begin
            push(vecs[i]);
            req_valid = 1'b0;
            wait_done();
        end

        // Finish pulses while idle must be ignored.
        idle_stray = 1'b1;
        repeat (4) tick();
        check("idle_stray", {28'd0, resp_valid, busy, mem_read, mem_write},
              32'd0);

        // Back-to-back: timeout stalls head, queue fills, order preserved.
        stalls = 0;
        for (int i = 4; i < 8; i++) begin
            push(vecs[i]);
            if (i == 6)
                check("queue_full", {30'd0, req_ready, busy}, 32'b01);
        end
        req_valid = 1'b0;
        wait_done();
        check("queue_stalled", 32'(stalls > 0), 32'd1);

        // Reset while a request is in flight and one is queued.
        mon_en    = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'h4AA;
        tick();
        req_addr  = 12'h4BB;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("pre_reset", {30'd0, mem_read, busy}, 32'b11);
        reset = 1'b1;
        tick();
        check("reset_mid_req",
              {27'd0, mem_read, mem_write, req_ready, busy, resp_valid},
              32'b00100);
        reset = 1'b0;
        bad = 0;
        repeat (12) begin
            tick();
            if (resp_valid || mem_read || mem_write || busy) bad++;
        end
        check("post_reset_quiet", bad, 0);

        // Normal operation resumes after reset.
        mon_en = 1'b1;
        tick();
        push(vecs[0]);
        req_valid = 1'b0;
        wait_done();

        check("scoreboard_empty", pending.size() + resp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
